reset_sequencer: RTL and testbench

- Parametrised power-on and button reset controller for the board top levels.
- Waits for all PLL lock inputs, holds reset for a fixed time, then releases NUM_STAGES reset outputs one after another, spaced by a fixed gap.
- Re-asserts resets on loss of lock or on a debounced button press.
- Replaces the ad-hoc auto-reset counter and the raw button OR in each top level. Feeds the reset_i of the SoC, the USB host and the peripheral subsystems.

---
 rtl/reset_sequencer.sv | 175 +++++++++++++++++
 tb/tb_reset_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Power-on / button reset sequencer.
// Waits for all PLL locks, holds reset, then releases the stage resets one at a
// time. Any loss of lock or debounced button press re-asserts every stage at once.
module reset_sequencer #(
   parameter int unsigned NUM_LOCKS       = 2,
   parameter int unsigned NUM_BTNS        = 1,
   parameter int unsigned BTN_ACTIVE_LOW  = 1,
   parameter int unsigned DEBOUNCE_CYCLES = 250000,
   parameter int unsigned HOLD_CYCLES     = 31,
   parameter int unsigned NUM_STAGES      = 3,
   parameter int unsigned STAGE_GAP       = 4
) (
   input  logic                  clk,
   input  logic                  reset_i,
   input  logic [NUM_LOCKS-1:0]  locks_i,
   input  logic [NUM_BTNS-1:0]   btn_i,
   output logic [NUM_STAGES-1:0] rst_o,
   output logic                  busy_o,
   output logic [7:0]            lock_loss_cnt_o
);

   localparam int unsigned CntMax = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
   localparam int unsigned CntW   = $clog2(CntMax + 1);
   localparam int unsigned DbW    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned StageW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

   localparam logic [CntW-1:0]   HoldLast  = CntW'(HOLD_CYCLES - 1);
   localparam logic [CntW-1:0]   GapLast   = CntW'(STAGE_GAP - 1);
   localparam logic [DbW-1:0]    DbLast    = DbW'(DEBOUNCE_CYCLES - 1);
   localparam logic [StageW-1:0] LastStage = StageW'(NUM_STAGES - 1);
   // Raw button level when not pressed
   localparam logic              BtnIdle   = (BTN_ACTIVE_LOW != 0);

   typedef enum logic [1:0] {StWaitLock, StHold, StRelease, StRun} state_e;

   logic [NUM_LOCKS-1:0]  lock_s1_q, lock_s2_q;
   logic [NUM_BTNS-1:0]   btn_s1_q, btn_s2_q;
   logic [NUM_BTNS-1:0]   btn_acc_q;
   logic [DbW-1:0]        db_cnt_q [NUM_BTNS];
   logic [NUM_BTNS-1:0]   btn_active;
   logic                  all_locked;
   logic                  pressed;

   state_e                state_q;
   logic [CntW-1:0]       cnt_q;
   logic [StageW-1:0]     stage_q;
   logic [NUM_STAGES-1:0] rst_q;
   logic                  busy_q;
   logic                  locked_prev_q;
   logic [7:0]            loss_cnt_q;

   // Two-flop synchronisers for the asynchronous lock and button inputs
   always_ff @(posedge clk) begin
      if (reset_i) begin
         lock_s1_q <= '0;
         lock_s2_q <= '0;
         btn_s1_q  <= '0;
         btn_s2_q  <= '0;
      end else begin
         lock_s1_q <= locks_i;
         lock_s2_q <= lock_s1_q;
         btn_s1_q  <= btn_i;
         btn_s2_q  <= btn_s1_q;
      end
   end

   // Per-button debounce: accept a new level after DEBOUNCE_CYCLES differing samples
   always_ff @(posedge clk) begin
      if (reset_i) begin
         btn_acc_q <= {NUM_BTNS{BtnIdle}};
         for (int unsigned i = 0; i < NUM_BTNS; i++) begin
            db_cnt_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NUM_BTNS; i++) begin
            if (btn_s2_q[i] == btn_acc_q[i]) begin
               db_cnt_q[i] <= '0;
            end else if (db_cnt_q[i] == DbLast) begin
               btn_acc_q[i] <= btn_s2_q[i];
               db_cnt_q[i]  <= '0;
            end else begin
               db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
            end
         end
      end
   end

   assign btn_active = BtnIdle ? ~btn_acc_q : btn_acc_q;
   assign pressed    = |btn_active;
   assign all_locked = &lock_s2_q;

   // Sequencing FSM with registered reset/busy outputs and lock-loss counter
   always_ff @(posedge clk) begin
      if (reset_i) begin
         state_q       <= StWaitLock;
         cnt_q         <= '0;
         stage_q       <= '0;
         rst_q         <= '1;
         busy_q        <= 1'b1;
         locked_prev_q <= 1'b0;
         loss_cnt_q    <= '0;
      end else begin
         locked_prev_q <= all_locked;
         if (locked_prev_q && !all_locked && (state_q != StWaitLock) && (loss_cnt_q != 8'hff)) begin
            loss_cnt_q <= loss_cnt_q + 8'd1;
         end

         unique case (state_q)
            StWaitLock: begin
               rst_q  <= '1;
               busy_q <= 1'b1;
               cnt_q  <= '0;
               if (all_locked && !pressed) begin
                  state_q <= StHold;
               end
            end

            StHold: begin
               if (!all_locked) begin
                  state_q <= StWaitLock;
                  cnt_q   <= '0;
               end else if (pressed) begin
                  cnt_q <= '0;
               end else if (cnt_q == HoldLast) begin
                  // Stage 0 drops on the same edge that leaves HOLD
                  cnt_q <= '0;
                  rst_q <= ~NUM_STAGES'(1);
                  if (NUM_STAGES == 1) begin
                     state_q <= StRun;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= StRelease;
                     stage_q <= StageW'(1);
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            StRelease, StRun: begin
               // Lock loss wins over a simultaneous press
               if (!all_locked) begin
                  state_q <= StWaitLock;
                  rst_q   <= '1;
                  busy_q  <= 1'b1;
                  cnt_q   <= '0;
               end else if (pressed) begin
                  state_q <= StHold;
                  rst_q   <= '1;
                  busy_q  <= 1'b1;
                  cnt_q   <= '0;
               end else if (state_q == StRelease) begin
                  if (cnt_q == GapLast) begin
                     cnt_q          <= '0;
                     rst_q[stage_q] <= 1'b0;
                     if (stage_q == LastStage) begin
                        state_q <= StRun;
                        busy_q  <= 1'b0;
                     end else begin
                        stage_q <= stage_q + 1'b1;
                     end
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
         endcase
      end
   end

   assign rst_o           = rst_q;
   assign busy_o          = busy_q;
   assign lock_loss_cnt_o = loss_cnt_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: timeline table, hand-written corner sequences and a
// randomized run against a timeline model (cycles since HOLD entry).
module tb_reset_sequencer;

   localparam int NL   = 2;
   localparam int NB   = 1;
   localparam int BAL  = 1;
   localparam int DEB  = 8;
   localparam int HOLD = 31;
   localparam int NS   = 3;
   localparam int GAP  = 4;

   logic          clk = 1'b0;
   logic          reset_i;
   logic [NL-1:0] locks_i;
   logic [NB-1:0] btn_i;
   logic [NS-1:0] rst_o;
   logic          busy_o;
   logic [7:0]    lock_loss_cnt_o;

   always #5 clk = ~clk;

   reset_sequencer #(
      .NUM_LOCKS      (NL),
      .NUM_BTNS       (NB),
      .BTN_ACTIVE_LOW (BAL),
      .DEBOUNCE_CYCLES(DEB),
      .HOLD_CYCLES    (HOLD),
      .NUM_STAGES     (NS),
      .STAGE_GAP      (GAP)
   ) dut (
      .clk            (clk),
      .reset_i        (reset_i),
      .locks_i        (locks_i),
      .btn_i          (btn_i),
      .rst_o          (rst_o),
      .busy_o         (busy_o),
      .lock_loss_cnt_o(lock_loss_cnt_o)
   );

   int total = 0;
   int bad   = 0;
   int ecnt  = 0;

   // Reference model: sync pipes, debounce window, and m_seq = cycles since
   // the sequence (re)started in HOLD, or -1 while waiting for lock.
   logic [NL-1:0] m_lk1, m_lk2;
   logic          m_bt1, m_bt2, m_acc, m_prev_lk;
   bit            m_hist[$];
   int            m_seq;
   int            m_loss;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s @edge %0d: got %0h want %0h", name, ecnt, got, exp);
      end
   endtask

   function automatic logic [NS-1:0] exp_rst();
      logic [NS-1:0] r;
      for (int k = 0; k < NS; k++) r[k] = (m_seq < 0) || (m_seq < HOLD + k * GAP);
      return r;
   endfunction

   function automatic logic exp_busy();
      return (m_seq < 0) || (m_seq < HOLD + (NS - 1) * GAP);
   endfunction

   task automatic model_edge();
      logic lk, pr, all_diff;
      if (reset_i) begin
         m_lk1 = '0; m_lk2 = '0; m_bt1 = 1'b0; m_bt2 = 1'b0;
         m_acc = (BAL != 0); m_prev_lk = 1'b0; m_hist.delete();
         m_seq = -1; m_loss = 0;
         return;
      end
      lk = &m_lk2;
      pr = (BAL != 0) ? ~m_acc : m_acc;
      if (m_prev_lk && !lk && m_seq >= 0 && m_loss < 255) m_loss++;
      m_prev_lk = lk;
      if (m_seq < 0) begin
         if (lk && !pr) m_seq = 0;
      end else if (!lk) m_seq = -1;
      else if (pr) m_seq = 0;
      else if (m_seq < 100000) m_seq++;
      m_hist.push_back(m_bt2);
      if (m_hist.size() > DEB) void'(m_hist.pop_front());
      if (m_hist.size() == DEB) begin
         all_diff = 1'b1;
         foreach (m_hist[j]) if (m_hist[j] == m_acc) all_diff = 1'b0;
         if (all_diff) begin
            m_acc = ~m_acc;
            m_hist.delete();
         end
      end
      m_lk2 = m_lk1; m_lk1 = locks_i;
      m_bt2 = m_bt1; m_bt1 = btn_i[0];
   endtask

   task automatic step();
      @(posedge clk);
      ecnt++;
      model_edge();
      #1;
      check("model rst_o", 32'(rst_o), 32'(exp_rst()));
      check("model busy_o", 32'(busy_o), 32'(exp_busy()));
      check("model lock_loss_cnt_o", 32'(lock_loss_cnt_o), 32'(m_loss));
   endtask

   task automatic run_to(input int e);
      while (ecnt < e) step();
   endtask

   task automatic do_reset();
      reset_i = 1'b1;
      step();
      check("reset rst_o", 32'(rst_o), 32'h7);
      check("reset busy_o", 32'(busy_o), 32'h1);
      check("reset loss", 32'(lock_loss_cnt_o), 32'h0);
      reset_i = 1'b0;
      ecnt = 0;
   endtask

   typedef struct {
      int            edge_n;
      logic [NS-1:0] rst;
      logic          busy;
   } vec_t;

   vec_t tbl [9];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int x, f, k, btn_left;

      tbl[0] = '{2,  3'b111, 1'b1};
      tbl[1] = '{3,  3'b111, 1'b1};
      tbl[2] = '{33, 3'b111, 1'b1};
      tbl[3] = '{34, 3'b110, 1'b1};
      tbl[4] = '{37, 3'b110, 1'b1};
      tbl[5] = '{38, 3'b100, 1'b1};
      tbl[6] = '{41, 3'b100, 1'b1};
      tbl[7] = '{42, 3'b000, 1'b0};
      tbl[8] = '{50, 3'b000, 1'b0};

      // Power-up with locks already high
      reset_i = 1'b1; locks_i = 2'b11; btn_i = 1'b1;
      do_reset();
      for (int i = 0; i < 9; i++) begin
         run_to(tbl[i].edge_n);
         check("powerup rst_o", 32'(rst_o), 32'(tbl[i].rst));
         check("powerup busy_o", 32'(busy_o), 32'(tbl[i].busy));
      end

      // Late lock
      locks_i = 2'b01;
      do_reset();
      run_to(100);
      check("latelock held", 32'(rst_o), 32'h7);
      x = ecnt;
      locks_i = 2'b11;
      run_to(x + 33);
      check("latelock pre", 32'(rst_o), 32'h7);
      run_to(x + 34);
      check("latelock rel0", 32'(rst_o), 32'h6);
      run_to(x + 42);
      check("latelock run", 32'(rst_o), 32'h0);
      check("latelock busy", 32'(busy_o), 32'h0);

      // One-cycle lock glitch in RUN
      x = ecnt;
      locks_i = 2'b10;
      step();
      locks_i = 2'b11;
      run_to(x + 2);
      check("glitch before", 32'(rst_o), 32'h0);
      run_to(x + 3);
      check("glitch reassert", 32'(rst_o), 32'h7);
      check("glitch loss", 32'(lock_loss_cnt_o), 32'h1);
      run_to(x + 34);
      check("glitch hold", 32'(rst_o), 32'h7);
      run_to(x + 35);
      check("glitch rel0", 32'(rst_o), 32'h6);
      run_to(x + 45);
      check("glitch run", 32'(rst_o), 32'h0);

      // Short button pulse is filtered
      x = ecnt;
      btn_i = 1'b0;
      repeat (5) step();
      btn_i = 1'b1;
      run_to(x + 25);
      check("btn short", 32'(rst_o), 32'h0);

      // Long press, then press again mid-RELEASE
      f = ecnt;
      btn_i = 1'b0;
      run_to(f + 10);
      check("btn pre", 32'(rst_o), 32'h0);
      run_to(f + 11);
      check("btn accept", 32'(rst_o), 32'h7);
      run_to(f + 20);
      btn_i = 1'b1;
      run_to(f + 52);
      btn_i = 1'b0;
      run_to(f + 60);
      check("btn rel pre", 32'(rst_o), 32'h7);
      run_to(f + 61);
      check("btn rel0", 32'(rst_o), 32'h6);
      run_to(f + 62);
      check("abort pre", 32'(rst_o), 32'h6);
      run_to(f + 63);
      check("abort all", 32'(rst_o), 32'h7);
      check("abort busy", 32'(busy_o), 32'h1);
      run_to(f + 70);
      btn_i = 1'b1;
      run_to(f + 110);
      check("abort rehold", 32'(rst_o), 32'h7);
      run_to(f + 111);
      check("abort rel0", 32'(rst_o), 32'h6);

      // Saturate the lock-loss counter
      for (int i = 0; i < 300; i++) begin
         locks_i = 2'b00;
         repeat (3) step();
         locks_i = 2'b11;
         repeat (5) step();
      end
      check("loss saturate", 32'(lock_loss_cnt_o), 32'hff);

      // Reset pulse mid-RELEASE
      k = 0;
      while (rst_o != 3'b110 && k < 100) begin
         step();
         k++;
      end
      check("reach release", 32'(rst_o), 32'h6);
      step();
      reset_i = 1'b1;
      step();
      check("midreset rst_o", 32'(rst_o), 32'h7);
      check("midreset busy", 32'(busy_o), 32'h1);
      check("midreset loss", 32'(lock_loss_cnt_o), 32'h0);
      reset_i = 1'b0;

      // Randomized run against the model
      btn_left = 0;
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 999) < 4) locks_i = 2'($urandom_range(0, 3));
         else if (locks_i != 2'b11 && $urandom_range(0, 7) == 0) locks_i = 2'b11;
         if (btn_left > 0) begin
            btn_i = 1'b0;
            btn_left--;
         end else begin
            btn_i = 1'b1;
            if ($urandom_range(0, 199) == 0) btn_left = $urandom_range(1, 20);
         end
         reset_i = ($urandom_range(0, 1999) == 0);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
